hub_normalizer: RTL
===================

Name: hub_normalizer

Overview:
- Post-addition normalizer for the FP HUB adder; the counterpart of the right-shift alignment step.
- Takes the raw significand sum plus the pre-normalization exponent and produces a normalized significand and adjusted exponent.
- Carry-out is handled by a 1-bit right shift. Cancellation is handled by a leading-zero count and a left shift.
- Two-stage pipeline with valid/ready handshake; sits between the significand adder and the result packer.

Parameters:
- M, 24, significand width including hidden bit.
- E, 8, exponent width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_sign  in  1  sign of the sum, passed through.
- in_exp  in  E  pre-normalization exponent (biased, unsigned).
- in_mant  in  M+1  raw sum: bit M is carry-out, bit M-1 is the normal leading-one position.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sign  out  1  sign.
- out_exp  out  E  normalized exponent.
- out_mant  out  M  normalized significand; bit M-1 = 1 unless the result is zero or flushed.
- out_zero  out  1  sum was exactly zero.
- out_ovf  out  1  exponent overflow; result is infinity encoding.
- out_unf  out  1  exponent underflow; result flushed to zero.

Behaviour:
- Reset: out_valid=0, all out_* data and flags=0, both stage valids=0. in_ready=1 in the first cycle after reset.
- A reset asserted mid-operation discards all in-flight beats; nothing is emitted.
- Handshake:
  - A beat transfers when valid and ready are both high in the same cycle.
  - Stage 2 advances when it is empty or out_ready=1.
  - Stage 1 advances when it is empty or stage 2 advances.
  - in_ready equals the stage-1 advance condition. It is combinational from out_ready; no combinational valid-to-ready path.
  - Output data and flags stay stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from an accepted input to out_valid. Full throughput is 1 beat/cycle. Beat order is preserved.
- Stage 1 registers sign, exp, mant, carry=in_mant[M], zero=(in_mant==0), and lz.
  - lz = count of leading zeros of in_mant[M-1:0] from bit M-1; range 0..M.
- Stage 2 selects exactly one case, in priority order:
  - zero: out_mant=0, out_exp=0, out_zero=1.
  - carry: out_mant=mant[M:1], out_exp=exp+1.
    - If exp+1 = 2^E-1: out_ovf=1, out_exp all ones, out_mant=0.
  - lz >= exp: out_unf=1, out_exp=0, out_mant=0 (no subnormals).
  - otherwise: out_mant = mant[M-1:0] << lz, out_exp = exp - lz.
- Arithmetic: exponent math is done in E+1 bits unsigned. lz is zero-extended to E+1 bits before the comparison. Flags are mutually exclusive.

Optional Feature:
- Macro: HUB_ILSB_FILL_EN.
- Defined: on a left shift with lz>0, the former implicit LSB becomes explicit.
  - out_mant bit (lz-1) is forced to 1 and the bits below it are 0.
  - Carry, zero, ovf and unf paths are unchanged.
- Undefined: the left shift inserts zeros only.

Decomposition:
- Shared package hub_pkg holds:
  - default M and E constants;
  - struct norm_stage_t {sign, exp, mant, lz, carry, zero}, used for the stage register;
  - localparam LZW = $clog2(M+1).
- One natural sub-module, hub_lzc: combinational leading-zero counter, M-bit input, LZW-bit output, returns M for all-zero input.

Test Plan (M=24, E=8):
- Carry: mant=25'h1800000, exp=127 -> out_mant=24'hC00000, exp=128, all flags 0, out_valid exactly 2 cycles after acceptance.
- Cancellation: mant=25'h0100000, exp=127 -> lz=3, out_mant=24'h800000 (24'h800004 with HUB_ILSB_FILL_EN), exp=124.
- Zero and underflow:
  - mant=0, exp=90 -> out_zero=1, exp=0, mant=0.
  - mant=25'h0000001, exp=10 -> out_unf=1, exp=0, mant=0.
- Overflow: mant=25'h1000000, exp=254 -> out_ovf=1, exp=8'hFF, mant=0.
- Backpressure: 4 back-to-back beats with out_ready=0 for 6 cycles -> in_ready drops after 2 beats are accepted; all 4 beats emerge in order, with data held stable while stalled.
- Reset mid-flight: rst pulsed with both stages full -> next cycle out_valid=0, in_ready=1, and no stale beat appears afterwards.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared types and constants for the FP HUB adder normalization path.
package hub_pkg;

    localparam int DEF_M = 24;
    localparam int DEF_E = 8;
    localparam int LZW   = $clog2(DEF_M + 1);

    // Contents of the stage-1 register: the raw sum plus its pre-computed shift.
    typedef struct packed {
        logic             sign;
        logic [DEF_E-1:0] exp;
        logic [DEF_M:0]   mant;
        logic [LZW-1:0]   lz;
        logic             carry;
        logic             zero;
    } norm_stage_t;

endpackage

// File: rtl/hub_lzc.sv
// Combinational leading-zero counter. It counts from the MSB and returns W for an all-zero input.
module hub_lzc
    import hub_pkg::*;
#(
    parameter int W   = DEF_M,
    parameter int CW  = LZW
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    logic found;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt   = CW'(W);
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && din[i]) begin
                cnt   = CW'(W - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hub_normalizer.sv
// Post-addition normalizer for the FP HUB adder. It is a two-stage valid/ready pipeline.
// Optional macro HUB_ILSB_FILL_EN: a left shift makes the former implicit LSB explicit.
module hub_normalizer
    import hub_pkg::*;
#(
    parameter int M = DEF_M,
    parameter int E = DEF_E
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sign,
    input  logic [E-1:0] in_exp,
    input  logic [M:0]   in_mant,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sign,
    output logic [E-1:0] out_exp,
    output logic [M-1:0] out_mant,
    output logic         out_zero,
    output logic         out_ovf,
    output logic         out_unf
);

    localparam logic [E:0] EXP_MAX = {1'b0, {E{1'b1}}};

    logic           s2_adv;
    logic           s1_adv;

    logic           s1_valid_q, s1_valid_d;
    norm_stage_t    s1_q, s1_d;

    logic           out_valid_q, out_valid_d;
    logic           out_sign_q,  out_sign_d;
    logic [E-1:0]   out_exp_q,   out_exp_d;
    logic [M-1:0]   out_mant_q,  out_mant_d;
    logic           out_zero_q,  out_zero_d;
    logic           out_ovf_q,   out_ovf_d;
    logic           out_unf_q,   out_unf_d;

    logic [LZW-1:0] lz_in;
    logic [E:0]     exp_ext;
    logic [E:0]     exp_inc;
    logic [E:0]     lz_ext;
    logic [M-1:0]   shifted;

    hub_lzc #(.W(M), .CW(LZW)) u_lzc (
        .din (in_mant[M-1:0]),
        .cnt (lz_in)
    );

    // Ready depends only on registered valids and out_ready. in_valid never reaches in_ready.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.sign  = in_sign;
                s1_d.exp   = in_exp;
                s1_d.mant  = in_mant;
                s1_d.lz    = lz_in;
                s1_d.carry = in_mant[M];
                s1_d.zero  = (in_mant == '0);
            end
        end
    end

    always_comb begin
        exp_ext = {1'b0, s1_q.exp};
        exp_inc = exp_ext + (E+1)'(1);
        lz_ext  = (E+1)'(s1_q.lz);
        shifted = s1_q.mant[M-1:0] << s1_q.lz;
`ifdef HUB_ILSB_FILL_EN
        if (s1_q.lz != '0) begin
            shifted = shifted | (M'(1) << (s1_q.lz - LZW'(1)));
        end
`endif
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_mant_d  = out_mant_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sign_d = s1_q.sign;
                out_zero_d = 1'b0;
                out_ovf_d  = 1'b0;
                out_unf_d  = 1'b0;
                if (s1_q.zero) begin
                    out_zero_d = 1'b1;
                    out_exp_d  = '0;
                    out_mant_d = '0;
                end else if (s1_q.carry) begin
                    // >= also covers an all-ones input exponent, whose increment would wrap.
                    if (exp_inc >= EXP_MAX) begin
                        out_ovf_d  = 1'b1;
                        out_exp_d  = '1;
                        out_mant_d = '0;
                    end else begin
                        out_exp_d  = exp_inc[E-1:0];
                        out_mant_d = s1_q.mant[M:1];
                    end
                end else if (lz_ext >= exp_ext) begin
                    out_unf_d  = 1'b1;
                    out_exp_d  = '0;
                    out_mant_d = '0;
                end else begin
                    out_exp_d  = E'(exp_ext - lz_ext);
                    out_mant_d = shifted;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only. Every flop takes its _d value computed in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_mant_q  <= out_mant_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_mant  = out_mant_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule
